calc_sequencer: RTL
===================

# calc_sequencer

Control sequencer for the calculator datapath. It collects operands and an operation from a command strobe interface, computes the 8-bit result in an internal ALU, and drives the result-holding register's `A`/`Sel` inputs. It holds the result stable before issuing the commit select code, so the holder's two-sample stability check always passes. It also issues the holder's clear code on request.

## Interface
Parameters:
- `HOLD_CYCLES`, default 2: number of cycles `sel_out` = 3'b011 is asserted per commit (legal range 1..15).

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command strobe; sampled each rising edge.
- `cmd`  in  3  000 NOP, 001 LOAD_A, 010 LOAD_B, 011 SET_OP, 100 EQUALS, 101 CLEAR, 110/111 illegal.
- `data_in`  in  8  operand for LOAD_A/LOAD_B; `[1:0]` is the op code for SET_OP (00 ADD, 01 SUB, 10 AND, 11 OR).
- `result_out`  out  8  result to the holder's `A`; registered.
- `sel_out`  out  3  holder select: 000 idle, 011 commit, 100 clear; registered.
- `carry`  out  1  ADD carry-out or SUB borrow of the last EQUALS; 0 for AND/OR.
- `busy`  out  1  high when state ≠ IDLE.
- `done`  out  1  one-cycle pulse in the last COMMIT cycle.
- `cmd_err`  out  1  one-cycle pulse: illegal command, or a non-NOP, non-CLEAR command while busy.

## Operation
- FSM states: IDLE, SETUP, COMMIT, CLEAR.
- IDLE:
  - LOAD_A sets `a`; LOAD_B sets `b`; SET_OP sets `op`. All take effect at the edge and stay in IDLE.
  - EQUALS: `result_out` ← alu(a,b,op), `carry` updated, `a` ← the same result (chaining), then go to SETUP.
  - CLEAR: go to the CLEAR state.
- SETUP: lasts one cycle with `sel_out`=000; the result is already stable. Then go to COMMIT.
- COMMIT: `sel_out`=011 for HOLD_CYCLES cycles. An internal counter counts down; `done` is high in the last cycle. Then go to IDLE and `sel_out` returns to 000.
- CLEAR state: `a`, `b`, `op`, `result_out` and `carry` are zeroed at entry. `sel_out`=100 for exactly one cycle, then go to IDLE with `sel_out`=000.
- CLEAR has priority in every state. It aborts SETUP or COMMIT, and the abort is not flagged as an error.
- While busy, LOAD/SET_OP/EQUALS are dropped with no state change, and `cmd_err` pulses. Illegal codes pulse `cmd_err` in any state. NOP never pulses `cmd_err`.
- Arithmetic:
  - ADD: 9-bit sum; `result_out` = sum[7:0], `carry` = sum[8]. Wraps mod 256.
  - SUB: `result_out` = (a−b) mod 256, `carry` = (a<b).
  - AND/OR: bitwise, `carry`=0.
- `result_out` must not change during SETUP or COMMIT. Only EQUALS and CLEAR alter it.

## Timing
- Reset (async assert, synchronous release): state IDLE; `a`=`b`=`result_out`=0; `op`=ADD; `sel_out`=000; `carry`=`busy`=`done`=`cmd_err`=0.
- EQUALS sampled at edge t:
  - New `result_out` visible after t.
  - `sel_out`=011 after t+1 through t+HOLD_CYCLES.
  - `sel_out`=000 after t+HOLD_CYCLES+1.
  - The holder latches at edge t+2, having seen A stable at t+1 and t+2.
- `busy` is high from after t until the edge that returns to IDLE. A new EQUALS is accepted, at the earliest, at the edge after `busy` falls.
- CLEAR at edge t: `sel_out`=100 for the cycle after t; IDLE after t+1.
- `done` and `cmd_err` are registered one-cycle pulses, asserted in the cycle after the causing edge (`done`: the last COMMIT cycle).
- Reset mid-COMMIT: outputs go to reset values immediately. No partial commit is guaranteed.

## Structure
- Package `calc_pkg`: command codes, op codes, select codes (SEL_IDLE, SEL_COMMIT, SEL_CLEAR), FSM state enum.
- Sub-module `calc_alu`: purely combinational. Inputs a, b, op; outputs 8-bit result and carry.
- Everything else (FSM, operand registers, hold counter) lives in `calc_sequencer`.

## Test plan
- Reset, then LOAD_A 0x05, LOAD_B 0x03, SET_OP ADD, EQUALS → `result_out`=0x08 the cycle after EQUALS; `sel_out`=011 on the two following cycles; `done` on the second; the holder model outputs 0x08.
- LOAD_A 0xF0, LOAD_B 0x20, ADD, EQUALS → 0x10 with `carry`=1. Then LOAD_B 0x20, SUB, EQUALS (chained a=0x10) → 0xF0 with `carry`=1.
- EQUALS, then LOAD_A 0x44 while busy → `cmd_err` pulse; `a` is unchanged and `result_out` stays stable through COMMIT.
- CLEAR during COMMIT → `sel_out`=100 for one cycle, `result_out`=0, `done` never pulses, IDLE next.
- `cmd`=3'b111 in IDLE → `cmd_err` pulse, no state change. Assert `reset_n` low mid-SETUP → all outputs zero asynchronously.
- HOLD_CYCLES=1 build: EQUALS with AND of 0xCC,0xAA → 0x88; `sel_out`=011 for exactly one cycle.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer: command, op and select
// codes, the FSM state encoding and small decode helpers.
package calc_pkg;

    localparam int DATA_W = 8;
    // Hold counter width; HOLD_CYCLES is legal in 1..15.
    localparam int CNT_W  = 4;

    typedef enum logic [2:0] {
        CMD_NOP    = 3'b000,
        CMD_LOAD_A = 3'b001,
        CMD_LOAD_B = 3'b010,
        CMD_SET_OP = 3'b011,
        CMD_EQUALS = 3'b100,
        CMD_CLEAR  = 3'b101
    } cmd_e;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } op_e;

    // Select codes driven to the result holder.
    localparam logic [2:0] SEL_IDLE   = 3'b000;
    localparam logic [2:0] SEL_COMMIT = 3'b011;
    localparam logic [2:0] SEL_CLEAR  = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_COMMIT = 2'b10,
        ST_CLEAR  = 2'b11
    } state_e;

    // Codes 110/111 are reserved and always rejected.
    function automatic logic cmd_is_legal(input logic [2:0] code);
        return (code <= 3'(CMD_CLEAR));
    endfunction

    // Commands that do real work and therefore must be refused while busy.
    function automatic logic cmd_needs_idle(input logic [2:0] code);
        return (code == 3'(CMD_LOAD_A)) || (code == 3'(CMD_LOAD_B)) ||
               (code == 3'(CMD_SET_OP)) || (code == 3'(CMD_EQUALS));
    endfunction

endpackage

// File: rtl/calc_if.sv
// Command strobe and result-holder bus between the sequencer and its user.
// The master drives commands; the slave (the sequencer) returns the result,
// the holder select code and status pulses.
interface calc_if;
    import calc_pkg::*;

    logic              cmd_valid;
    logic [2:0]        cmd;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] result_out;
    logic [2:0]        sel_out;
    logic              carry;
    logic              busy;
    logic              done;
    logic              cmd_err;

    modport master (
        output cmd_valid,
        output cmd,
        output data_in,
        input  result_out,
        input  sel_out,
        input  carry,
        input  busy,
        input  done,
        input  cmd_err
    );

    modport slave (
        input  cmd_valid,
        input  cmd,
        input  data_in,
        output result_out,
        output sel_out,
        output carry,
        output busy,
        output done,
        output cmd_err
    );

endinterface

// File: rtl/calc_alu.sv
// Combinational 8-bit ALU: ADD with carry-out, SUB with borrow, bitwise AND/OR.
module calc_alu
    import calc_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  op_e               i_op,
    output logic [DATA_W-1:0] o_result,
    output logic              o_carry
);

    logic [DATA_W:0]   w_sum;
    logic [DATA_W:0]   w_diff;
    logic [DATA_W-1:0] w_and;
    logic [DATA_W-1:0] w_or;

    // Zero-extended so bit 8 is the carry on add and the borrow on subtract.
    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};

    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_bitwise
            assign w_and[gi] = i_a[gi] & i_b[gi];
            assign w_or[gi]  = i_a[gi] | i_b[gi];
        end
    endgenerate

    // Result and carry selection by op code; logic ops never carry.
    always_comb begin
        o_result = w_sum[DATA_W-1:0];
        o_carry  = 1'b0;
        case (i_op)
            OP_ADD: begin
                o_result = w_sum[DATA_W-1:0];
                o_carry  = w_sum[DATA_W];
            end
            OP_SUB: begin
                o_result = w_diff[DATA_W-1:0];
                o_carry  = w_diff[DATA_W];
            end
            OP_AND: o_result = w_and;
            OP_OR:  o_result = w_or;
            default: begin
                o_result = w_sum[DATA_W-1:0];
                o_carry  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/calc_sequencer.sv
// Calculator control sequencer. Collects operands and an op code from the
// command strobe, evaluates on EQUALS, then walks IDLE -> SETUP -> COMMIT so
// the holder sees a stable result for at least two samples before it latches.
// CLEAR overrides everything and drives the holder's clear code for one cycle.
module calc_sequencer
    import calc_pkg::*;
#(
    // Cycles of SEL_COMMIT per commit, legal 1..15.
    parameter int HOLD_CYCLES = 2
)(
    input  logic  clock,
    input  logic  reset_n,
    calc_if.slave bus
);

    state_e            r_state;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    op_e               r_op;
    logic [DATA_W-1:0] r_result;
    logic              r_carry;
    logic [2:0]        r_sel;
    logic              r_busy;
    logic              r_done;
    logic              r_cmd_err;
    logic [CNT_W-1:0]  r_cnt;

    logic [DATA_W-1:0] w_alu_result;
    logic              w_alu_carry;
    logic              w_clear;
    logic              w_err;

    calc_alu u_alu (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_op     (r_op),
        .o_result (w_alu_result),
        .o_carry  (w_alu_carry)
    );

    // CLEAR wins in every state and is never reported as an error, even when
    // it aborts a commit in progress.
    assign w_clear = bus.cmd_valid && (bus.cmd == 3'(CMD_CLEAR));

    // Reserved codes are always errors; real work is refused outside IDLE.
    assign w_err = bus.cmd_valid &&
                   (!cmd_is_legal(bus.cmd) ||
                    ((r_state != ST_IDLE) && cmd_needs_idle(bus.cmd)));

    // Sequencer FSM with operand registers, hold counter and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= OP_ADD;
            r_result  <= '0;
            r_carry   <= 1'b0;
            r_sel     <= SEL_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cmd_err <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_done    <= 1'b0;
            r_cmd_err <= 1'b0;
            if (w_clear) begin
                r_state  <= ST_CLEAR;
                r_a      <= '0;
                r_b      <= '0;
                r_op     <= OP_ADD;
                r_result <= '0;
                r_carry  <= 1'b0;
                r_sel    <= SEL_CLEAR;
                r_busy   <= 1'b1;
                r_cnt    <= '0;
            end else begin
                r_cmd_err <= w_err;
                case (r_state)
                    ST_IDLE: begin
                        if (bus.cmd_valid) begin
                            case (bus.cmd)
                                CMD_LOAD_A: r_a  <= bus.data_in;
                                CMD_LOAD_B: r_b  <= bus.data_in;
                                CMD_SET_OP: r_op <= op_e'(bus.data_in[1:0]);
                                CMD_EQUALS: begin
                                    // Result is chained back into a so the
                                    // next EQUALS continues from it.
                                    r_result <= w_alu_result;
                                    r_carry  <= w_alu_carry;
                                    r_a      <= w_alu_result;
                                    r_state  <= ST_SETUP;
                                    r_busy   <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                    ST_SETUP: begin
                        // One quiet cycle so the holder sees the new result
                        // before the commit code appears.
                        r_state <= ST_COMMIT;
                        r_sel   <= SEL_COMMIT;
                        r_cnt   <= CNT_W'(HOLD_CYCLES - 1);
                        r_done  <= (HOLD_CYCLES == 1);
                    end
                    ST_COMMIT: begin
                        if (r_cnt == '0) begin
                            r_state <= ST_IDLE;
                            r_sel   <= SEL_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_cnt  <= r_cnt - CNT_W'(1);
                            r_done <= (r_cnt == CNT_W'(1));
                        end
                    end
                    ST_CLEAR: begin
                        r_state <= ST_IDLE;
                        r_sel   <= SEL_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_sel   <= SEL_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.result_out = r_result;
    assign bus.sel_out    = r_sel;
    assign bus.carry      = r_carry;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.cmd_err    = r_cmd_err;

endmodule
